// File: rtl/adder_pipe.sv
// adder_pipe: elastic pipelined WIDTH-bit adder, {c_out,sum} = a + b + c_in after STAGES register stages
//   Parameters: WIDTH (1..32) operand width, STAGES (1..4) register stages
//   Ports: clk, rst (async active-low), valid_in/ready_in/a/b/c_in (input handshake),
//          valid_out/ready_out/sum/c_out (output handshake), ovf (signed overflow)
//   Optional feature: define ADDER_PIPE_OVF_EN to add the ovf port and its pipeline bit
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);
`ifdef ADDER_PIPE_OVF_EN
  localparam int DW = WIDTH + 2;
`else
  localparam int DW = WIDTH + 1;
`endif
  logic [WIDTH:0]    total;
  logic [DW-1:0]     din;
  logic [DW-1:0]     data [STAGES];
  logic [DW-1:0]     dp [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] vp;
  logic [STAGES-1:0] adv;
  logic              full;
  assign total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
`ifdef ADDER_PIPE_OVF_EN
  assign din = {(a[WIDTH-1] == b[WIDTH-1]) && (total[WIDTH-1] != a[WIDTH-1]), total};
  assign {ovf, c_out, sum} = data[STAGES-1];
`else
  assign din = total;
  assign {c_out, sum} = data[STAGES-1];
`endif
  assign valid_out = v[STAGES-1];
  assign ready_in  = adv[0];
  // A stage may advance whenever any stage at or after it is empty, or the sink takes the output.
  always_comb begin
    full = 1'b1;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full   = full & v[k];
      adv[k] = ready_out | ~full;
    end
  end
  always_comb begin
    vp    = '0;
    dp    = '{default: '0};
    vp[0] = valid_in;
    dp[0] = din;
    for (int k = 1; k < STAGES; k++) begin
      vp[k] = v[k-1];
      dp[k] = data[k-1];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v    <= '0;
      data <= '{default: '0};
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v[k]    <= vp[k];
          data[k] <= dp[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: scoreboard bench running three adder_pipe configurations side by side
module tb_adder_pipe;
  logic clk = 1'b0;
  int   checks = 0;
  int   passed = 0;
  always #5 clk = ~clk;

  task automatic chk(input int id, input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL c%0d_%s: got %0h expected %0h", id, nm, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = g == 0 ? 8 : g == 1 ? 1 : 32;
    localparam int S = g == 0 ? 2 : g == 1 ? 1 : 4;
    logic rst, valid_in, ready_in, valid_out, ready_out, c_in, c_out;
    logic [W-1:0] a, b, sum;
`ifdef ADDER_PIPE_OVF_EN
    logic ovf;
`endif
    logic [W+1:0] q [$];
    bit fin = 0;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
      .a(a), .b(b), .c_in(c_in), .valid_out(valid_out), .ready_out(ready_out),
      .sum(sum), .c_out(c_out)
`ifdef ADDER_PIPE_OVF_EN
      , .ovf(ovf)
`endif
    );

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      longint t, sx, sy, st, lo, hi;
      t  = longint'(x) + longint'(y) + longint'(c);
      sx = longint'(x) - (x[W-1] ? (longint'(1) << W) : 0);
      sy = longint'(y) - (y[W-1] ? (longint'(1) << W) : 0);
      st = sx + sy + longint'(c);
      lo = -(longint'(1) << (W - 1));
      hi = (longint'(1) << (W - 1)) - 1;
      return {st < lo || st > hi, t[W:0]};
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c);
      int n = 0;
      valid_in = 1; a = x[W-1:0]; b = y[W-1:0]; c_in = c;
      @(negedge clk);
      while (!ready_in && n < 200) begin @(negedge clk); n++; end
      if (!ready_in) chk(g, 0, "send_timeout", 0, 1);
      @(posedge clk); #1;
      valid_in = 0;
    endtask

    task automatic lat(input logic [31:0] x, input logic [31:0] y, input logic c);
      int n = 1;
      ready_out = 1;
      send(x, y, c);
      while (!valid_out && n < 20) begin @(posedge clk); #1; n++; end
      chk(g, n == S, "latency", n, S);
    endtask

    task automatic drain(input string nm);
      repeat (S + 2) @(posedge clk);
      #1;
      chk(g, q.size() == 0, {nm, "_queue_empty"}, q.size(), 0);
      chk(g, !valid_out, {nm, "_idle"}, valid_out, 0);
    endtask

    initial begin
      logic [W+1:0] e;
      bit hv = 0;
      logic [W:0] hd = '0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          q.delete();
          hv = 0;
        end else begin
          if (hv) chk(g, valid_out && {c_out, sum} == hd, "hold", {valid_out, c_out, sum}, {1'b1, hd});
          hv = valid_out && !ready_out;
          hd = {c_out, sum};
          if (valid_out && ready_out) begin
            if (q.size() == 0) chk(g, 0, "unexpected_output", {c_out, sum}, 0);
            else begin
              e = q.pop_front();
              chk(g, {c_out, sum} == e[W:0], "result", {c_out, sum}, e[W:0]);
`ifdef ADDER_PIPE_OVF_EN
              chk(g, ovf == e[W+1], "ovf", ovf, e[W+1]);
`endif
            end
          end
          if (valid_in && ready_in) q.push_back(model(a, b, c_in));
        end
      end
    end

    initial begin
      logic [31:0] r;
      rst = 0; valid_in = 0; ready_out = 1; a = '0; b = '0; c_in = 0;
      repeat (2) @(posedge clk);
      #1;
      chk(g, !valid_out, "rst_valid_out", valid_out, 0);
      chk(g, {c_out, sum} == '0, "rst_data", {c_out, sum}, 0);
      chk(g, ready_in, "rst_ready_in", ready_in, 1);
      rst = 1;
      lat(32'h0F, 32'h01, 0);
      send(32'hFF, 32'h01, 1);
      send(32'h7F, 32'h01, 0);
      drain("directed");
      for (int i = 0; i < 10; i++) begin
        r = i; valid_in = 1; a = r[W-1:0]; b = r[W-1:0]; c_in = 0;
        @(negedge clk);
        chk(g, ready_in, "stream_ready", ready_in, 1);
        if (i >= S) chk(g, valid_out, "stream_throughput", valid_out, 1);
        @(posedge clk); #1;
      end
      valid_in = 0;
      drain("stream");
      ready_out = 0;
      for (int i = 0; i < S; i++) send(32'h10 + i, 32'h3 + i, 1'(i));
      r = $urandom; valid_in = 1; a = r[W-1:0]; b = ~r[W-1:0]; c_in = 1;
      repeat (3) begin
        @(negedge clk);
        chk(g, !ready_in, "full_ready_low", ready_in, 0);
      end
      @(posedge clk); #1;
      ready_out = 1;
      @(negedge clk);
      chk(g, ready_in, "full_same_cycle_accept", ready_in, 1);
      @(posedge clk); #1;
      valid_in = 0;
      drain("backpressure");
      for (int i = 0; i < 400; i++) begin
        ready_out = $urandom_range(3) != 0;
        valid_in = $urandom_range(1) == 1;
        r = $urandom; a = $urandom_range(7) == 0 ? '1 : r[W-1:0];
        r = $urandom; b = r[W-1:0];
        c_in = $urandom_range(1) == 1;
        @(posedge clk); #1;
      end
      valid_in = 0; ready_out = 1;
      drain("random");
      ready_out = 0;
      for (int i = 0; i < (S < 2 ? S : 2); i++) send(32'h21, 32'h22, 1);
      rst = 0;
      #1;
      chk(g, !valid_out, "midrst_valid_out", valid_out, 0);
      chk(g, {c_out, sum} == '0, "midrst_data", {c_out, sum}, 0);
`ifdef ADDER_PIPE_OVF_EN
      chk(g, !ovf, "midrst_ovf", ovf, 0);
`endif
      chk(g, ready_in, "midrst_ready_in", ready_in, 1);
      @(posedge clk); #1;
      rst = 1;
      lat(32'h05, 32'h06, 0);
      drain("after_reset");
      fin = 1;
    end
  end

  initial begin
    int cyc = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && cyc < 50000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
      checks++;
      $display("FAIL timeout: got %0d cycles without completion, expected all configs done", cyc);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
